// File: rtl/mcycle_ctrl.sv
// Multicycle MIPS main controller: sequences one instruction at a time through
// fetch/decode/execute/memory/writeback and counts retired instructions.
module mcycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcen,
    output logic             irwrite,
    output logic             memwrite,
    output logic             iord,
    output logic             regwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [1:0]       aluop,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t cur, nxt;
    logic   pcwrite, branch;

    assign state = cur;

    always_ff @(posedge clk) begin
        if (reset) cur <= S_FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        nxt = S_FETCH;
        unique case (cur)
            S_FETCH:   nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_RTYPEEX;
                    OP_BEQ:       nxt = S_BEQEX;
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JEX;
                    default:      nxt = S_FETCH;
                endcase
            end
            S_MEMADR:  nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: nxt = S_RTYPEWB;
            S_ADDIEX:  nxt = S_ADDIWB;
            default:   nxt = S_FETCH;
        endcase
    end

    // Reset forces the stalled-FETCH outputs so nothing writes while reset is high.
    always_comb begin
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        if (reset) begin
            alusrcb = 2'b01;
        end else begin
            unique case (cur)
                S_FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    illegal_op = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
                end
                S_MEMADR, S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: iord = 1'b1;
                S_MEMWB: begin
                    memtoreg   = 1'b1;
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    iord       = 1'b1;
                    memwrite   = 1'b1;
                    instr_done = mem_ready;
                end
                S_RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                S_RTYPEWB: begin
                    regdst     = 1'b1;
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BEQEX: begin
                    alusrca    = 1'b1;
                    aluop      = 2'b01;
                    pcsrc      = 2'b01;
                    branch     = 1'b1;
                    instr_done = 1'b1;
                end
                S_ADDIWB: begin
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_JEX: begin
                    pcsrc      = 2'b10;
                    pcwrite    = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pcen = pcwrite | (branch & zero);

    always_ff @(posedge clk) begin
        if (reset)           retired <= '0;
        else if (instr_done) retired <= retired + CNT_W'(1);
    end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Cycle-table bench for mcycle_ctrl: each record is one cycle of inputs and the
// expected state / control word / retired count, checked through a scoreboard.
module tb_mcycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic        zero;
    logic        mem_ready;
    logic        pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca;
    logic [1:0]  alusrcb, pcsrc, aluop;
    logic [3:0]  state;
    logic        instr_done, illegal_op;
    logic [31:0] retired;
    logic        pcen4, irwrite4, memwrite4, iord4, regwrite4, regdst4, memtoreg4, alusrca4;
    logic [1:0]  alusrcb4, pcsrc4, aluop4;
    logic [3:0]  state4;
    logic        instr_done4, illegal_op4;
    logic [3:0]  retired4;

    always #5 clk = ~clk;

    mcycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .iord(iord),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .state(state),
        .instr_done(instr_done), .illegal_op(illegal_op), .retired(retired)
    );

    mcycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen4), .irwrite(irwrite4), .memwrite(memwrite4), .iord(iord4),
        .regwrite(regwrite4), .regdst(regdst4), .memtoreg(memtoreg4), .alusrca(alusrca4),
        .alusrcb(alusrcb4), .pcsrc(pcsrc4), .aluop(aluop4), .state(state4),
        .instr_done(instr_done4), .illegal_op(illegal_op4), .retired(retired4)
    );

    // Control word bits: pcen irwrite memwrite iord regwrite regdst memtoreg alusrca
    //                    alusrcb[1:0] pcsrc[1:0] aluop[1:0] instr_done illegal_op
    localparam logic [15:0] C_FETCH  = 16'hC040, C_FSTALL = 16'h0040;
    localparam logic [15:0] C_DEC    = 16'h00C0, C_DECILL = 16'h00C1;
    localparam logic [15:0] C_MEMADR = 16'h0180, C_MEMRD  = 16'h1000;
    localparam logic [15:0] C_MEMWB  = 16'h0A02;
    localparam logic [15:0] C_WRWAIT = 16'h3000, C_WRDONE = 16'h3002;
    localparam logic [15:0] C_REX    = 16'h0108, C_RWB    = 16'h0C02;
    localparam logic [15:0] C_BEQT   = 16'h8116, C_BEQN   = 16'h0116;
    localparam logic [15:0] C_AEX    = 16'h0180, C_AWB    = 16'h0802;
    localparam logic [15:0] C_JEX    = 16'h8022;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, ILL = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        mr;
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic [31:0] ret;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   vidx = 0;

    task automatic add(input logic r, input logic [5:0] o, input logic z, input logic m,
                       input logic [3:0] s, input logic [15:0] c, input logic [31:0] rt);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.mr = m; v.st = s; v.ctrl = c; v.ret = rt;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, vidx, act, req);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        logic [15:0] ctrl_act;
        @(negedge clk);
        reset = v.rst; op = v.op; zero = v.zero; mem_ready = v.mr;
        exp_q.push_back(v);
        #2;
        e = exp_q.pop_front();
        ctrl_act = {pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca,
                    alusrcb, pcsrc, aluop, instr_done, illegal_op};
        cmp("state", 32'(state), 32'(e.st));
        cmp("ctrl", 32'(ctrl_act), 32'(e.ctrl));
        cmp("retired", retired, e.ret);
        vidx++;
    endtask

    initial begin
        // reset masks mem_ready
        add(1, RT, 0, 1, 0, C_FSTALL, 0);
        // lw, then FETCH stall and decode ignoring mem_ready
        add(0, LW, 0, 1, 0, C_FETCH, 0);
        add(0, LW, 0, 0, 1, C_DEC, 0);
        add(0, LW, 0, 0, 2, C_MEMADR, 0);
        add(0, LW, 0, 1, 3, C_MEMRD, 0);
        add(0, LW, 0, 1, 4, C_MEMWB, 0);
        // sw with 3 stall cycles in MEMWR
        add(0, SW, 0, 0, 0, C_FSTALL, 1);
        add(0, SW, 0, 1, 0, C_FETCH, 1);
        add(0, SW, 0, 1, 1, C_DEC, 1);
        add(0, SW, 0, 1, 2, C_MEMADR, 1);
        add(0, SW, 0, 0, 5, C_WRWAIT, 1);
        add(0, SW, 0, 0, 5, C_WRWAIT, 1);
        add(0, SW, 0, 0, 5, C_WRWAIT, 1);
        add(0, SW, 0, 1, 5, C_WRDONE, 1);
        // beq taken / not taken
        add(0, BEQ, 0, 1, 0, C_FETCH, 2);
        add(0, BEQ, 1, 1, 1, C_DEC, 2);
        add(0, BEQ, 1, 1, 8, C_BEQT, 2);
        add(0, BEQ, 1, 1, 0, C_FETCH, 3);
        add(0, BEQ, 1, 1, 1, C_DEC, 3);
        add(0, BEQ, 0, 1, 8, C_BEQN, 3);
        // R-type then j
        add(0, RT, 1, 1, 0, C_FETCH, 4);
        add(0, RT, 1, 1, 1, C_DEC, 4);
        add(0, RT, 1, 1, 6, C_REX, 4);
        add(0, RT, 1, 1, 7, C_RWB, 4);
        add(0, JMP, 0, 1, 0, C_FETCH, 5);
        add(0, JMP, 0, 1, 1, C_DEC, 5);
        add(0, JMP, 0, 0, 11, C_JEX, 5);
        // illegal opcode
        add(0, ILL, 0, 1, 0, C_FETCH, 6);
        add(0, ILL, 0, 1, 1, C_DECILL, 6);
        add(0, ILL, 0, 1, 0, C_FETCH, 6);
        // sw stalled in MEMWR, then reset mid-stall
        add(0, SW, 0, 1, 1, C_DEC, 6);
        add(0, SW, 0, 1, 2, C_MEMADR, 6);
        add(0, SW, 0, 0, 5, C_WRWAIT, 6);
        add(1, SW, 0, 0, 5, C_FSTALL, 6);
        add(0, SW, 0, 0, 0, C_FSTALL, 0);
        // 16 addi instructions for the counter-wrap check
        for (int i = 0; i < 16; i++) begin
            add(0, ADDI, 0, 1, 0, C_FETCH, 32'(i));
            add(0, ADDI, 0, 1, 1, C_DEC, 32'(i));
            add(0, ADDI, 0, 1, 9, C_AEX, 32'(i));
            add(0, ADDI, 0, 1, 10, C_AWB, 32'(i));
        end
        add(0, ADDI, 0, 0, 0, C_FSTALL, 16);

        reset = 1'b1; op = RT; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            if (i == 35) begin
                // both counters were cleared by the preceding reset
                cmp("retired4_cleared", 32'(retired4), 32'd0);
            end
            apply(vecs[i]);
        end
        cmp("retired4_wrap", 32'(retired4), 32'd0);
        cmp("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcycle_ctrl.md
# mcycle_ctrl

Multicycle main controller for the MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback states. Each cycle it drives the datapath mux selects and write enables, plus the 2-bit `aluop` that the ALU decoder expands into the 3-bit ALU control. Memory accesses stall on a `mem_ready` handshake, and retired instructions are counted.

## Interface
- `CNT_W`, 32, width of the retired-instruction counter
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`
- `op`  in  6  opcode field of the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory has completed the access presented this cycle
- `pcen`  out  1  PC write enable = `pcwrite | (branch & zero)`
- `irwrite`  out  1  instruction register load
- `memwrite`  out  1  memory write strobe
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `regwrite`  out  1  register file write
- `regdst`  out  1  0 = rt, 1 = rd
- `memtoreg`  out  1  0 = ALUOut, 1 = memory data
- `alusrca`  out  1  0 = PC, 1 = rs
- `alusrcb`  out  2  00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- `pcsrc`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `aluop`  out  2  00 = add, 01 = sub, 10 = decode funct
- `state`  out  4  current state encoding (debug)
- `instr_done`  out  1  one-cycle pulse on the final cycle of each instruction
- `illegal_op`  out  1  one-cycle pulse in DECODE when the opcode is unsupported
- `retired`  out  CNT_W  count of completed instructions

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- Outputs not listed for a state are 0.
- **FETCH**: alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=`mem_ready`. Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- **DECODE**: alusrcb=11, aluop=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → RTYPEEX
  - 000100 (beq) → BEQEX
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JEX
  - any other opcode → FETCH, with `illegal_op`=1 and no `instr_done`
- **MEMADR**: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw, using `op` sampled this cycle.
- **MEMRD**: iord=1. Waits for `mem_ready`, then goes to MEMWB.
- **MEMWB**: memtoreg=1, regwrite=1, instr_done=1 → FETCH.
- **MEMWR**: iord=1, memwrite=1, held until `mem_ready`. On the `mem_ready` cycle: instr_done=1 → FETCH.
- **RTYPEEX**: alusrca=1, alusrcb=00, aluop=10 → RTYPEWB.
- **RTYPEWB**: regdst=1, regwrite=1, instr_done=1 → FETCH.
- **BEQEX**: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, instr_done=1 → FETCH.
- **ADDIEX**: alusrca=1, alusrcb=10, aluop=00 → ADDIWB.
- **ADDIWB**: regwrite=1, instr_done=1 → FETCH.
- **JEX**: pcsrc=10, pcwrite=1, instr_done=1 → FETCH.
- `branch` and `pcwrite` are internal signals; only `pcen` is exported.
- `retired` increments by 1 on every cycle with `instr_done`=1 and wraps modulo 2^CNT_W.

## Timing
- `state` is a register; all outputs are combinational from `state`, `op`, `zero` and `mem_ready`.
- The `mem_ready` qualification applies only in FETCH, MEMRD and MEMWR.
- **Reset**: on the first rising edge with `reset`=1, `state`=FETCH and `retired`=0, regardless of the current state, including mid-instruction or during a memory stall.
  - While `reset`=1 the outputs are the FETCH outputs with `mem_ready` forced to 0: every enable and strobe is 0, alusrcb=01, `instr_done`=0, `illegal_op`=0.
  - No write enable may be asserted while `reset` is high.
- Latency with `mem_ready` held at 1, FETCH through the last cycle:
  - lw: 5 cycles
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - illegal opcode: 2
- Each stall cycle in FETCH, MEMRD or MEMWR adds one cycle.
- `mem_ready` is ignored in all other states.
- `zero` affects only `pcen` in BEQEX.
- The cycle with `instr_done`=1 is always followed by FETCH.

## Test plan
- Reset mid-stall: assert `reset` in MEMWR with `mem_ready`=0 → next cycle `state`=0, memwrite=0, `retired`=0.
- lw (op=100011), `mem_ready`=1 → state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; `retired` goes 0→1.
- sw with `mem_ready` low for 3 cycles in MEMWR → memwrite=1 for 4 consecutive cycles, iord=1 throughout; `instr_done` pulses once, on the `mem_ready` cycle.
- beq taken and not taken (op=000100):
  - `zero`=1 → in state 8, pcen=1, pcsrc=01, aluop=01
  - `zero`=0 → pcen=0
  - both cases return to FETCH after 3 cycles.
- R-type then j:
  - R-type → aluop=10 in state 6; regdst=1, regwrite=1 in state 7
  - j (000010) → pcen=1, pcsrc=10 in state 11
  - `retired` increments by 2 in total.
- Illegal op=111111 → `illegal_op` pulses in DECODE, no write enables, state returns to 0, `retired` unchanged.
- Counter wrap with CNT_W=4 → after 16 addi instructions `retired`=0.
